// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and constants for the RSA engine arbiter
package rsa_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int RSA_WIDTH = 16;

    localparam logic RSP_ERR_NONE  = 1'b0;
    localparam logic RSP_ERR_FAULT = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first request at or after ptr
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   idx
);

    int pos;

    // Scan from the farthest offset back to ptr so the nearest request is written last.
    always_comb begin
        winner = '0;
        idx    = '0;
        pos    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % NREQ;
            if (req[pos]) begin
                winner      = '0;
                winner[pos] = 1'b1;
                idx         = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/rsa_engine_arbiter.sv
// rtl/rsa_engine_arbiter.sv - round-robin sharing of one modexp engine; RSA_ARB_TIMEOUT_EN adds a WAIT watchdog
module rsa_engine_arbiter
    import rsa_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int WIDTH     = RSA_WIDTH,
    parameter int TO_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  Rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_msg,
    input  logic [NREQ*WIDTH-1:0] req_exp,
    input  logic [NREQ*WIDTH-1:0] req_mod,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  eng_load,
    output logic [WIDTH-1:0]      eng_msg,
    output logic [WIDTH-1:0]      eng_exp,
    output logic [WIDTH-1:0]      eng_mod,
    input  logic                  eng_done,
    input  logic [WIDTH-1:0]      eng_result
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 2) begin : g_bad_param
        $error("rsa_engine_arbiter: NREQ must be 2..8 and TO_CYCLES at least 2");
    end

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, win_idx, pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic [WIDTH-1:0] sel_msg, sel_exp, sel_mod;
    logic            mod_zero;
    logic            timeout;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_oh),
        .idx    (pick_idx)
    );

    assign sel_msg  = req_msg[int'(pick_idx)*WIDTH +: WIDTH];
    assign sel_exp  = req_exp[int'(pick_idx)*WIDTH +: WIDTH];
    assign sel_mod  = req_mod[int'(pick_idx)*WIDTH +: WIDTH];
    assign mod_zero = (sel_mod == '0);

`ifdef RSA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES);
    logic [CW-1:0] wait_cnt;

    // Counts completed WAIT cycles; the TO_CYCLES-th WAIT cycle gives up on the engine.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst)
            wait_cnt <= '0;
        else if (state != WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = (state == WAIT) && (wait_cnt == CW'(TO_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = mod_zero ? RESP : LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (eng_done || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        eng_load = (state == LAUNCH);
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            gnt       <= '0;
            win_idx   <= '0;
            ptr       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= RSP_ERR_NONE;
            eng_msg   <= '0;
            eng_exp   <= '0;
            eng_mod   <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: if (|req) begin
                    gnt     <= pick_oh;
                    win_idx <= pick_idx;
                    eng_msg <= sel_msg;
                    eng_exp <= sel_exp;
                    eng_mod <= sel_mod;
                    if (mod_zero) begin
                        rsp_data <= '0;
                        rsp_err  <= RSP_ERR_FAULT;
                    end
                end
                WAIT: if (eng_done) begin
                    rsp_data <= eng_result;
                    rsp_err  <= RSP_ERR_NONE;
                end else if (timeout) begin
                    rsp_data <= '0;
                    rsp_err  <= RSP_ERR_FAULT;
                end
                RESP: begin
                    // A requester that dropped its request forfeits the strobe.
                    rsp_valid <= gnt & req;
                    gnt       <= '0;
                    ptr       <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// tb/tb_rsa_engine_arbiter.sv - self-checking bench for rsa_engine_arbiter
module tb_rsa_engine_arbiter;

    localparam int NREQ  = 2;
    localparam int WIDTH = 16;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_msg, req_exp, req_mod;
    logic [WIDTH-1:0]      msg_a [NREQ];
    logic [WIDTH-1:0]      exp_a [NREQ];
    logic [WIDTH-1:0]      mod_a [NREQ];
    logic [NREQ-1:0]       gnt, rsp_valid;
    logic [WIDTH-1:0]      rsp_data, eng_msg, eng_exp, eng_mod, eng_result;
    logic                  rsp_err, busy, eng_load, eng_done;

    always_comb begin
        req_msg = '0;
        req_exp = '0;
        req_mod = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_msg[i*WIDTH +: WIDTH] = msg_a[i];
            req_exp[i*WIDTH +: WIDTH] = exp_a[i];
            req_mod[i*WIDTH +: WIDTH] = mod_a[i];
        end
    end

    rsa_engine_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TO_CYCLES(TO)) dut (
        .clk        (clk),
        .Rst        (rst),
        .req        (req),
        .req_msg    (req_msg),
        .req_exp    (req_exp),
        .req_mod    (req_mod),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .eng_load   (eng_load),
        .eng_msg    (eng_msg),
        .eng_exp    (eng_exp),
        .eng_mod    (eng_mod),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc, m_ptr, exp_win, exp_lat, gnt_cyc, last_rsp_cyc, eng_cnt, eng_lat;
    bit pending, eng_hang;
    logic [WIDTH-1:0] exp_data, eng_res_pend;
    logic             exp_err;
    logic [NREQ-1:0]  req_seen, prev_gnt, sticky, dropped;
    int               served [$];
    logic [WIDTH-1:0] res_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] modexp(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                                                input logic [WIDTH-1:0] n);
        longint r, b, nn;
        if (n == '0) return '0;
        nn = longint'(n);
        r  = 1 % nn;
        b  = longint'(m) % nn;
        for (int i = 0; i < WIDTH; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return WIDTH'(r);
    endfunction

    task automatic set_req(input int ch, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                           input logic [WIDTH-1:0] n);
        msg_a[ch] = m;
        exp_a[ch] = e;
        mod_a[ch] = n;
        req[ch]   = 1'b1;
    endtask

    // One clock: engine model, requester model, and the arbiter reference model.
    task automatic tick();
        int idx;
        req_seen = req;
        dropped  = '0;
        @(posedge clk);
        #1;
        cyc++;
        if (eng_cnt > 0) begin
            eng_cnt--;
            eng_done   = (eng_cnt == 0);
            eng_result = eng_res_pend;
        end else begin
            eng_done = 1'b0;
        end
        if (eng_load && !eng_hang) begin
            eng_cnt      = eng_lat;
            eng_res_pend = modexp(eng_msg, eng_exp, eng_mod);
        end
        if (rsp_valid != '0) begin
            check("rsp_expected", 64'(pending), 64'd1);
            check("rsp_valid", 64'(rsp_valid), 64'(NREQ'(1) << exp_win));
            check("rsp_data", 64'(rsp_data), 64'(exp_data));
            check("rsp_err", 64'(rsp_err), 64'(exp_err));
            check("rsp_latency", 64'(cyc - gnt_cyc), 64'(exp_lat));
            served.push_back(exp_win);
            res_q.push_back(rsp_data);
            last_rsp_cyc = cyc;
            m_ptr   = (exp_win + 1) % NREQ;
            pending = 1'b0;
            if (!sticky[exp_win]) begin
                req[exp_win]     = 1'b0;
                dropped[exp_win] = 1'b1;
            end
        end else if (pending && (cyc - gnt_cyc > exp_lat)) begin
            check("rsp_missing", 64'(cyc - gnt_cyc), 64'(exp_lat));
            pending = 1'b0;
        end
        if (gnt != '0 && prev_gnt == '0) begin
            exp_win = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (exp_win < 0 && req_seen[idx]) exp_win = idx;
            end
            if (exp_win < 0) begin
                check("gnt_spurious", 64'(gnt), 64'd0);
            end else begin
                check("gnt_winner", 64'(gnt), 64'(NREQ'(1) << exp_win));
                check("eng_load", 64'(eng_load), 64'(mod_a[exp_win] != '0));
                if (mod_a[exp_win] == '0) begin
                    exp_data = '0;
                    exp_err  = 1'b1;
                    exp_lat  = 1;
                end else if (eng_hang) begin
                    exp_data = '0;
                    exp_err  = 1'b1;
                    exp_lat  = TO + 2;
                end else begin
                    exp_data = modexp(msg_a[exp_win], exp_a[exp_win], mod_a[exp_win]);
                    exp_err  = 1'b0;
                    exp_lat  = eng_lat + 2;
                end
                pending = 1'b1;
                gnt_cyc = cyc;
            end
        end
        prev_gnt = gnt;
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (req == '0 && !pending) return;
            tick();
        end
        check("idle_timeout", 64'({req, pending}), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, 64'(gnt), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_eng_load"}, 64'(eng_load), 64'd0);
        check({tag, "_eng_ops"}, 64'({eng_msg, eng_exp, eng_mod}), 64'd0);
    endtask

    task automatic clear_model();
        req      = '0;
        sticky   = '0;
        pending  = 1'b0;
        m_ptr    = 0;
        eng_cnt  = 0;
        eng_done = 1'b0;
        eng_hang = 1'b0;
        prev_gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            msg_a[i] = '0;
            exp_a[i] = '0;
            mod_a[i] = '0;
        end
    endtask

    initial begin
        clear_model();
        eng_result = '0;
        eng_lat    = 20;
        cyc        = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // ch0 alone: 9^3 mod 33 = 3, engine latency 20
        set_req(0, 16'd9, 16'd3, 16'd33);
        cyc = 0;
        tick();
        check("t1_gnt_c1", 64'(gnt), 64'd1);
        check("t1_load_c1", 64'(eng_load), 64'd1);
        check("t1_busy_c1", 64'(busy), 64'd1);
        check("t1_ops", 64'({eng_msg, eng_exp, eng_mod}), {16'd0, 16'd9, 16'd3, 16'd33});
        wait_idle(100);
        check("t1_rsp_cycle", 64'(last_rsp_cyc), 64'd23);
        check("t1_result", 64'(res_q[$]), 64'd3);

        // ch0 and ch1 together from pointer 0
        rst = 1'b1;
        #1;
        @(negedge clk) rst = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        served.delete();
        res_q.delete();
        eng_lat = 5;
        set_req(0, 16'd9, 16'd3, 16'd33);
        set_req(1, 16'd4, 16'd2, 16'd7);
        wait_idle(200);
        check("t2_count", 64'(served.size()), 64'd2);
        check("t2_first", 64'(served[0]), 64'd0);
        check("t2_second", 64'(served[1]), 64'd1);
        check("t2_res0", 64'(res_q[0]), 64'd3);
        check("t2_res1", 64'(res_q[1]), 64'd2);

        // ch1 held high; ch0 arrives during ch1 service and must win next
        served.delete();
        sticky[1] = 1'b1;
        set_req(1, 16'd4, 16'd2, 16'd7);
        for (int k = 0; k < 50 && gnt != 2'b10; k++) tick();
        check("t3_ch1_granted", 64'(gnt), 64'd2);
        set_req(0, 16'd9, 16'd3, 16'd33);
        for (int k = 0; k < 100 && served.size() < 2; k++) tick();
        sticky[1] = 1'b0;
        wait_idle(200);
        check("t3_count", 64'(served.size()), 64'd3);
        check("t3_order0", 64'(served[0]), 64'd1);
        check("t3_order1", 64'(served[1]), 64'd0);
        check("t3_order2", 64'(served[2]), 64'd1);

        // mod 0 bypasses the engine
        tick();
        set_req(0, 16'd5, 16'd7, 16'd0);
        cyc = 0;
        tick();
        check("t4_no_load", 64'(eng_load), 64'd0);
        wait_idle(20);
        check("t4_rsp_cycle", 64'(last_rsp_cyc), 64'd2);
        check("t4_err", 64'(rsp_err), 64'd1);

        // reset during WAIT, pointer is at 1 beforehand
        eng_lat = 20;
        set_req(1, 16'd4, 16'd2, 16'd7);
        repeat (5) tick();
        check("t5_busy_before", 64'(busy), 64'd1);
        #3 rst = 1'b1;
        #1;
        check_zero("t5_async");
        @(negedge clk) rst = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        served.delete();
        eng_lat = 3;
        set_req(0, 16'd9, 16'd3, 16'd33);
        set_req(1, 16'd4, 16'd2, 16'd7);
        wait_idle(100);
        check("t5_ptr_reset", 64'(served[0]), 64'd0);
        check("t5_ch1_served", 64'(served[1]), 64'd1);

`ifdef RSA_ARB_TIMEOUT_EN
        // engine never answers: watchdog fires on the 16th WAIT cycle
        eng_hang = 1'b1;
        set_req(0, 16'd9, 16'd3, 16'd33);
        cyc = 0;
        wait_idle(100);
        check("t6_rsp_cycle", 64'(last_rsp_cyc), 64'(TO + 3));
        check("t6_err", 64'(rsp_err), 64'd1);
        eng_hang   = 1'b0;
        eng_result = 16'h1234;
        eng_done   = 1'b1;
        repeat (4) tick();
        check("t6_late_done", 64'({busy, rsp_valid}), 64'd0);
`endif

        // random traffic against the reference model
        eng_lat = int'($urandom_range(1, 6));
        for (int c = 0; c < 800; c++) begin
            for (int ch = 0; ch < NREQ; ch++) begin
                if (!req[ch] && !dropped[ch] && $urandom_range(0, 3) == 0)
                    set_req(ch, WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(0, 65535)),
                            ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom_range(1, 65535)));
            end
            tick();
        end
        wait_idle(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_engine_arbiter.md
Name: rsa_engine_arbiter

Overview:
Round-robin arbiter/sequencer that shares one modular-exponentiation engine (exp + mod chain) between NREQ requesters, e.g. encrypt and decrypt channels. Captures the winner's operands, pulses the engine load, waits for engine done, and returns the result to the granted requester. Sits between channel controllers and the single RSA datapath.

Parameters:
NREQ, 2, number of requesters (2..8)
WIDTH, 16, operand/result width
TO_CYCLES, 4096, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on posedge
Rst  in  1  reset, asynchronous, active-high
req  in  NREQ  per-requester request level; held high until its rsp_valid
req_msg  in  NREQ*WIDTH  message per requester, slice i = [i*WIDTH +: WIDTH]
req_exp  in  NREQ*WIDTH  exponent (key) per requester
req_mod  in  NREQ*WIDTH  modulus per requester
gnt  out  NREQ  one-hot grant, high from LAUNCH through RESP
rsp_valid  out  NREQ  one-cycle result strobe to the granted requester
rsp_data  out  WIDTH  result, valid when any rsp_valid is high
rsp_err  out  1  error flag qualifying rsp_valid
busy  out  1  high in any state except IDLE
eng_load  out  1  one-cycle engine start pulse
eng_msg, eng_exp, eng_mod  out  WIDTH each  registered operands to engine, stable LAUNCH..RESP
eng_done  in  1  engine completion; eng_result valid same cycle
eng_result  in  WIDTH  engine result

Behaviour:
- Reset (async, Rst=1): state=IDLE, rr pointer=0, every output 0 (gnt, rsp_valid, rsp_data, rsp_err, busy, eng_load, eng_msg/exp/mod).
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if |req, pick winner = first set bit at or after pointer (wrapping mod NREQ); register gnt, capture operands; go LAUNCH. If captured mod == 0, skip engine: go RESP with rsp_data=0, rsp_err=1.
- LAUNCH: eng_load=1 exactly this cycle; go WAIT.
- WAIT: eng_done ignored outside WAIT. On eng_done, latch eng_result into rsp_data, rsp_err=0; go RESP.
- RESP: rsp_valid[winner]=1 for one cycle if req[winner] is still high, else result discarded (no strobe). Pointer = winner+1 (wraps to 0 after NREQ-1). gnt clears on the next cycle; go IDLE.
- Latency: req sampled in cycle 0 → gnt and eng_load in cycle 1 → rsp_valid in cycle (engine cycles + 3). Minimum back-to-back spacing between grants: one IDLE cycle.
- Requests arriving during busy wait; there is no preemption. Operand changes after capture are ignored.
- Simultaneous requests: rr order. After reset, ch0 beats ch1.
- Mid-operation Rst: immediate return to reset values. The engine is reset by the same Rst externally.

Optional Feature:
RSA_ARB_TIMEOUT_EN: adds a WAIT-state cycle counter. If the counter reaches TO_CYCLES without eng_done, go RESP with rsp_data=0 and rsp_err=1, and advance the pointer normally. A late eng_done is ignored. Without the macro there is no counter, and WAIT persists until eng_done.

Decomposition:
- Package rsa_pkg: state enum (IDLE/LAUNCH/WAIT/RESP), WIDTH default constant, and the error encoding constant.
- One sub-module, rr_pick: combinational round-robin picker. Inputs req and pointer; outputs one-hot winner and index.

Test Plan:
- ch0 req msg=9, exp=3, mod=33, behavioural engine latency 20 → eng_load in cycle 1; rsp_valid[0] at cycle 23 with rsp_data=3, rsp_err=0.
- ch0 and ch1 requesting together after reset (ch1: msg=4, exp=2, mod=7) → ch0 served first (result 3), then ch1 (result 2); gnt is never two-hot.
- ch1 held continuously, ch0 requests again while ch1 is being served → next grant is ch0, proving rr fairness.
- ch0 mod=0 → no eng_load; rsp_valid[0] with rsp_data=0 and rsp_err=1 at cycle 2.
- Rst asserted during WAIT → all outputs 0 asynchronously; after release, a new ch1 request is served normally with the pointer at 0.
- With RSA_ARB_TIMEOUT_EN and TO_CYCLES=16, engine never done → rsp_err=1 at the 16th WAIT cycle; a later eng_done has no effect.
